// File: rtl/security_pkg.sv
// Shared definitions for the security front-end and the alarm state machine.
`timescale 1ns/1ps
package security_pkg;

  // Keypad command codes; 0x0-0x9 are digits, 0xD-0xF are unused.
  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  // Keypad sequencer states.
  typedef enum logic [1:0] {
    KP_IDLE    = 2'd0,
    KP_COLLECT = 2'd1,
    KP_CHECK   = 2'd2,
    KP_LOCKOUT = 2'd3
  } kp_state_t;

  // Alarm state machine states (consumer of the validated commands).
  typedef enum logic [2:0] {
    ALM_DISARMED    = 3'd0,
    ALM_EXIT_DELAY  = 3'd1,
    ALM_ARMED       = 3'd2,
    ALM_ENTRY_DELAY = 3'd3,
    ALM_ALARM       = 3'd4
  } alarm_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable down-counter; o_expired pulses for one cycle as the count leaves 1.
`timescale 1ns/1ps
module sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load has priority; counting stops at zero so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = i_en && !i_load && (r_cnt == W'(1));

endmodule

// File: rtl/keypad_sequencer.sv
// Collects PIN digits, validates them and emits one-cycle arm/disarm/fail pulses,
// with a lockout after repeated failed checks.
`timescale 1ns/1ps
module keypad_sequencer
  import security_pkg::*;
#(
  parameter int PIN_LEN     = 4,
  parameter int TIMEOUT_CYC = 100,
  parameter int LOCKOUT_CYC = 1000,
  parameter int MAX_FAIL    = 3,
  parameter logic [4*PIN_LEN-1:0] PIN_DEFAULT = 16'h1234
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  input  logic                 pin_load,
  input  logic [4*PIN_LEN-1:0] pin_value,
  output logic                 cmd_arm,
  output logic                 cmd_disarm,
  output logic                 fail_pulse,
  output logic                 locked,
  output logic [2:0]           digit_cnt
);

  localparam int BW   = 4 * PIN_LEN;
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int LK_W = $clog2(LOCKOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYC);
  localparam logic [LK_W-1:0] LK_LOAD  = LK_W'(LOCKOUT_CYC);
  localparam logic [2:0]      FULL_CNT = 3'(PIN_LEN);
  localparam logic [2:0]      MAX_F    = 3'(MAX_FAIL);

  kp_state_t r_state, w_next;

  logic [BW-1:0] r_buf, r_pin;
  logic [2:0]    r_digit_cnt, r_fail_cnt;
  logic          r_op_arm;
  logic          r_cmd_arm, r_cmd_disarm, r_fail_pulse;

  logic       w_is_digit, w_match;
  logic [2:0] w_fail_inc;
  logic       w_shift, w_clear, w_latch_op, w_pass, w_fail, w_pin_ld;
  logic       w_to_load, w_to_en, w_to_exp;
  logic       w_lock_start, w_lock_done, w_lk_en, w_lk_exp;

  assign w_is_digit = key_valid && is_digit(key_code);
  assign w_match    = (r_digit_cnt == FULL_CNT) && (r_buf == r_pin);
  assign w_fail_inc = r_fail_cnt + 3'd1;
  assign w_to_en    = (r_state == KP_COLLECT);
  assign w_lk_en    = (r_state == KP_LOCKOUT);

  sec_timer #(.W(TO_W)) u_entry_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_to_load),
    .i_load_val (TO_LOAD),
    .i_en       (w_to_en),
    .o_expired  (w_to_exp)
  );

  sec_timer #(.W(LK_W)) u_lock_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lock_start),
    .i_load_val (LK_LOAD),
    .i_en       (w_lk_en),
    .o_expired  (w_lk_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= KP_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath control; keys are decoded only in IDLE and COLLECT.
  always_comb begin
    w_next       = r_state;
    w_shift      = 1'b0;
    w_clear      = 1'b0;
    w_latch_op   = 1'b0;
    w_pass       = 1'b0;
    w_fail       = 1'b0;
    w_pin_ld     = 1'b0;
    w_to_load    = 1'b0;
    w_lock_start = 1'b0;
    w_lock_done  = 1'b0;
    case (r_state)
      KP_IDLE: begin
        w_pin_ld = pin_load;
        if (w_is_digit) begin
          w_shift   = 1'b1;
          w_to_load = 1'b1;
          w_next    = KP_COLLECT;
        end
      end
      KP_COLLECT: begin
        if (w_is_digit && (r_digit_cnt < FULL_CNT)) begin
          w_shift   = 1'b1;
          w_to_load = 1'b1;
        end else if (key_valid && (key_code == KEY_CLEAR)) begin
          w_clear = 1'b1;
          w_next  = KP_IDLE;
        end else if (key_valid && ((key_code == KEY_ARM) || (key_code == KEY_DISARM))) begin
          w_latch_op = 1'b1;
          w_next     = KP_CHECK;
        end else if (w_to_exp) begin
          w_clear = 1'b1;
          w_next  = KP_IDLE;
        end
      end
      KP_CHECK: begin
        w_clear = 1'b1;
        w_next  = KP_IDLE;
        if (w_match) begin
          w_pass = 1'b1;
        end else begin
          w_fail = 1'b1;
          if (w_fail_inc == MAX_F) begin
            w_lock_start = 1'b1;
            w_next       = KP_LOCKOUT;
          end
        end
      end
      KP_LOCKOUT: begin
        if (w_lk_exp) begin
          w_lock_done = 1'b1;
          w_next      = KP_IDLE;
        end
      end
      default: w_next = KP_IDLE;
    endcase
  end

  // Digit buffer, stored PIN and latched operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_digit_cnt <= '0;
      r_pin       <= PIN_DEFAULT;
      r_op_arm    <= 1'b0;
    end else begin
      if (w_clear) begin
        r_buf       <= '0;
        r_digit_cnt <= '0;
      end else if (w_shift) begin
        r_buf       <= (r_buf << 4) | BW'(key_code);
        r_digit_cnt <= r_digit_cnt + 3'd1;
      end
      if (w_latch_op) r_op_arm <= (key_code == KEY_ARM);
      if (w_pin_ld)   r_pin    <= pin_value;
    end
  end

  // Failure counter and the registered result pulses (high the cycle after CHECK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt   <= '0;
      r_cmd_arm    <= 1'b0;
      r_cmd_disarm <= 1'b0;
      r_fail_pulse <= 1'b0;
    end else begin
      if (w_pass || w_lock_done) r_fail_cnt <= '0;
      else if (w_fail)           r_fail_cnt <= w_fail_inc;
      r_cmd_arm    <= w_pass && r_op_arm;
      r_cmd_disarm <= w_pass && !r_op_arm;
      r_fail_pulse <= w_fail;
    end
  end

  assign cmd_arm    = r_cmd_arm;
  assign cmd_disarm = r_cmd_disarm;
  assign fail_pulse = r_fail_pulse;
  assign locked     = (r_state == KP_LOCKOUT);
  assign digit_cnt  = r_digit_cnt;

endmodule

// File: tb/tb_keypad_sequencer.sv
// Directed, table-driven bench for keypad_sequencer.
`timescale 1ns/1ps
module tb_keypad_sequencer;
  import security_pkg::*;

  localparam int PIN_LEN     = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int LOCKOUT_CYC = 1000;
  localparam int MAX_FAIL    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        pin_load = 1'b0;
  logic [15:0] pin_value = 16'h0;
  logic        cmd_arm, cmd_disarm, fail_pulse, locked;
  logic [2:0]  digit_cnt;

  always #5 clk = ~clk;

  keypad_sequencer #(
    .PIN_LEN(PIN_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .LOCKOUT_CYC(LOCKOUT_CYC),
    .MAX_FAIL(MAX_FAIL), .PIN_DEFAULT(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .pin_load(pin_load), .pin_value(pin_value), .cmd_arm(cmd_arm),
    .cmd_disarm(cmd_disarm), .fail_pulse(fail_pulse), .locked(locked),
    .digit_cnt(digit_cnt)
  );

  // res bits: {arm, disarm, fail}; term marks ARM/DISARM entries that trigger a check
  typedef struct {
    logic [3:0] key;
    logic [2:0] cnt;
    logic       term;
    logic [2:0] res;
  } vec_t;

  vec_t vecs[$];
  int   segs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [3:0] k, input logic [2:0] c,
                              input logic t, input logic [2:0] r);
    vec_t v;
    v.key = k; v.cnt = c; v.term = t; v.res = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic load_pin(input logic [15:0] v, input logic with_key, input logic [3:0] k);
    @(posedge clk); #1;
    pin_load = 1'b1; pin_value = v; key_valid = with_key; key_code = k;
    @(posedge clk); #1;
    pin_load = 1'b0; key_valid = 1'b0; key_code = 4'h0;
  endtask

  // Called in the CHECK cycle: nothing yet, then the expected pulse, then quiet.
  task automatic expect_out(input string name, input logic [2:0] res);
    chk({name, "_chkcyc"}, {29'd0, cmd_arm, cmd_disarm, fail_pulse}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_pulse"}, {29'd0, cmd_arm, cmd_disarm, fail_pulse}, {29'd0, res});
    chk({name, "_cnt0"}, {29'd0, digit_cnt}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_after"}, {29'd0, cmd_arm, cmd_disarm, fail_pulse}, 32'd0);
  endtask

  task automatic apply(input int idx);
    vec_t  v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    press(v.key);
    if (v.term) begin
      expect_out(nm, v.res);
    end else begin
      chk({nm, "_cnt"}, {29'd0, digit_cnt}, {29'd0, v.cnt});
      chk({nm, "_quiet"}, {29'd0, cmd_arm, cmd_disarm, fail_pulse}, 32'd0);
      @(posedge clk); #1;
      chk({nm, "_quiet2"}, {29'd0, cmd_arm, cmd_disarm, fail_pulse}, 32'd0);
    end
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
  endtask

  task automatic run_seg(input int s);
    run_range(segs[s], segs[s+1] - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  g;
    logic bad;
    logic [3:0] lk_keys [5];

    // seg 0: ignored codes in IDLE, correct ARM, overflow digit, CLEAR then DISARM
    segs.push_back(vecs.size());
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b0, 3'b000));
    vecs.push_back(mk(4'hD,       3'd0, 1'b0, 3'b000));
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b100));
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(4'h9,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(4'hE,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b100));
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_CLEAR,  3'd0, 1'b0, 3'b000));
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_DISARM, 3'd0, 1'b1, 3'b010));
    // seg 1: short entry after timeout
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h3,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b001));
    // seg 2: loaded PIN 0042 disarms, old PIN fails
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h0,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h0,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_DISARM, 3'd0, 1'b1, 3'b010));
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b001));
    // seg 3: first half of 0042
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h0,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h0,       3'd2, 1'b0, 3'b000));
    // seg 4: rest of 0042 after an ignored pin_load
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h4,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b100));
    // seg 5: remainder of 1234 after pin_load + digit in the same cycle
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b100));
    // seg 6: wrong PIN 1235 with DISARM
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h5,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_DISARM, 3'd0, 1'b1, 3'b001));
    // seg 7: correct 1234 ARM
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b100));
    // seg 8: 1234 ARM against a loaded 5678 fails
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    vecs.push_back(mk(4'h3,       3'd3, 1'b0, 3'b000));
    vecs.push_back(mk(4'h4,       3'd4, 1'b0, 3'b000));
    vecs.push_back(mk(KEY_ARM,    3'd0, 1'b1, 3'b001));
    // seg 9: partial entry before reset
    segs.push_back(vecs.size());
    vecs.push_back(mk(4'h1,       3'd1, 1'b0, 3'b000));
    vecs.push_back(mk(4'h2,       3'd2, 1'b0, 3'b000));
    segs.push_back(vecs.size());

    // Reset state
    #2;
    chk("rst_outs", {28'd0, cmd_arm, cmd_disarm, fail_pulse, locked}, 32'd0);
    chk("rst_cnt", {29'd0, digit_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_seg(0);

    // Entry timeout: T idle cycles keep the entry, the next one discards it
    press(4'h1);
    press(4'h2);
    chk("to_cnt_start", {29'd0, digit_cnt}, 32'd2);
    repeat (TIMEOUT_CYC - 1) begin @(posedge clk); #1; end
    chk("to_cnt_last", {29'd0, digit_cnt}, 32'd2);
    @(posedge clk); #1;
    chk("to_cnt_clear", {29'd0, digit_cnt}, 32'd0);
    run_seg(1);

    // PIN load in IDLE, ignored in COLLECT, and combined with a digit
    load_pin(16'h0042, 1'b0, 4'h0);
    run_seg(2);
    run_seg(3);
    load_pin(16'h1111, 1'b0, 4'h0);
    chk("ld_collect_cnt", {29'd0, digit_cnt}, 32'd2);
    run_seg(4);
    load_pin(16'h1234, 1'b1, 4'h1);
    chk("ld_digit_cnt", {29'd0, digit_cnt}, 32'd1);
    run_seg(5);

    // Lockout after MAX_FAIL consecutive failures
    run_seg(6);
    run_seg(6);
    chk("pre_lock", {31'd0, locked}, 32'd0);
    run_range(segs[6], segs[7] - 2);
    press(KEY_DISARM);
    @(posedge clk); #1;
    chk("lock_fail3", {31'd0, fail_pulse}, 32'd1);
    chk("lock_on", {31'd0, locked}, 32'd1);
    n = 1;
    lk_keys[0] = 4'h1; lk_keys[1] = 4'h2; lk_keys[2] = 4'h3;
    lk_keys[3] = 4'h4; lk_keys[4] = KEY_ARM;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      press(lk_keys[k]);
      n += 2;
      if (digit_cnt != 3'd0 || !locked) bad = 1'b1;
    end
    chk("lock_keys_ignored", {31'd0, bad}, 32'd0);
    bad = 1'b0;
    g = 0;
    while (locked && g < 2 * LOCKOUT_CYC) begin
      if (cmd_arm || cmd_disarm || fail_pulse) bad = 1'b1;
      @(posedge clk); #1;
      g++;
      if (locked) n++;
    end
    chk("lock_len", n, LOCKOUT_CYC);
    chk("lock_quiet", {31'd0, bad}, 32'd0);
    chk("lock_off", {31'd0, locked}, 32'd0);
    run_seg(7);

    // Reset mid-entry clears fail count, buffer and loaded PIN
    load_pin(16'h5678, 1'b0, 4'h0);
    run_seg(8);
    run_seg(8);
    run_seg(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {28'd0, cmd_arm, cmd_disarm, fail_pulse, locked}, 32'd0);
    chk("mid_rst_cnt", {29'd0, digit_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seg(6);
    chk("post_rst_nolock", {31'd0, locked}, 32'd0);
    run_seg(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_sequencer.md
Name: keypad_sequencer

Overview:
Front-end controller for the security FSM. It collects PIN digits from the keypad and validates them against a stored code. On a match it issues single-cycle arm/disarm commands; on a mismatch it counts the failure and enforces a lockout after repeated failures. It sits between the raw keypad decoder and the alarm state machine, so the alarm FSM sees only validated one-cycle commands.

Parameters:
PIN_LEN, 4, number of digits in a PIN (1..7)
TIMEOUT_CYC, 100, idle cycles in COLLECT before the entry is discarded
LOCKOUT_CYC, 1000, cycles the keypad stays locked after MAX_FAIL failures
MAX_FAIL, 3, consecutive failed checks that trigger lockout (1..7)
PIN_DEFAULT, 16'h1234, PIN after reset; one nibble per digit, first digit in the MS nibble

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  key_code is valid this cycle (one-cycle strobe per keypress)
key_code  in  4  0x0-0x9 digit, 0xA ARM, 0xB DISARM, 0xC CLEAR, 0xD-0xF ignored
pin_load  in  1  load pin_value as the new PIN
pin_value  in  4*PIN_LEN  new PIN, first digit in the MS nibble
cmd_arm  out  1  one-cycle pulse: valid PIN followed by ARM
cmd_disarm  out  1  one-cycle pulse: valid PIN followed by DISARM
fail_pulse  out  1  one-cycle pulse: check failed
locked  out  1  high for the whole lockout period
digit_cnt  out  3  digits currently buffered

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state = IDLE; all outputs 0.
  - Digit buffer 0; fail_cnt 0; pin_reg = PIN_DEFAULT; both timers cleared.
- States: IDLE, COLLECT, CHECK, LOCKOUT (2-bit encoding).
- IDLE:
  - A digit shifts in: buf = {buf, digit}; digit_cnt = 1; go to COLLECT.
  - ARM, DISARM, CLEAR and codes 0xD-0xF are ignored.
  - pin_load is honoured only in IDLE. If pin_load and a digit arrive in the same cycle, both take effect.
- COLLECT:
  - Digit with digit_cnt < PIN_LEN: shift in, digit_cnt++.
  - Digit with digit_cnt == PIN_LEN: ignored; no overflow, no wrap.
  - CLEAR: buffer and digit_cnt cleared; go to IDLE; no failure counted.
  - ARM/DISARM: latch the operation; go to CHECK regardless of digit_cnt.
  - Timeout: the timer reloads on every accepted key. After TIMEOUT_CYC cycles without a key, clear the buffer and go to IDLE; no failure counted.
  - pin_load is ignored.
- CHECK (exactly one cycle; all keys and pin_load ignored):
  - Match means digit_cnt == PIN_LEN and buf == pin_reg.
  - On a match: the cmd_arm or cmd_disarm register is set at the end of CHECK, so the pulse is high in the cycle after CHECK. Latency from the ARM/DISARM key edge to the command pulse is 2 clocks. fail_cnt is cleared; go to IDLE.
  - On a mismatch: fail_pulse in the same slot; fail_cnt++. If the new fail_cnt == MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
  - Buffer and digit_cnt are cleared on leaving CHECK.
- LOCKOUT:
  - locked = 1; all keys and pin_load are ignored.
  - After LOCKOUT_CYC cycles: locked = 0, fail_cnt = 0, go to IDLE.
- Command and fail pulses never overlap. At most one of cmd_arm, cmd_disarm, fail_pulse is high in any cycle.
- Reset asserted mid-operation aborts immediately to the reset values. A PIN loaded earlier is lost and pin_reg returns to PIN_DEFAULT.
- Widths:
  - digit_cnt saturates at PIN_LEN.
  - Timers are sized $clog2 of their parameter plus 1 and never wrap.

Decomposition:
- Shared package security_pkg holds:
  - key code constants KEY_ARM, KEY_DISARM, KEY_CLEAR;
  - the state encoding for this block;
  - the existing alarm FSM state constants.
- One sub-module, sec_timer: a loadable down-counter with load, enable and a one-cycle expired output. It is instantiated twice, once for the entry timeout and once for the lockout.

Test Plan:
- Reset; keys 1,2,3,4,ARM -> cmd_arm high for exactly 1 cycle, 2 clocks after the ARM strobe; fail_pulse stays 0; digit_cnt returns to 0.
- 1,2,3,5,DISARM three times -> fail_pulse three times. After the third, locked = 1 for LOCKOUT_CYC cycles; 1,2,3,4,ARM during lockout gives no command; afterwards locked = 0 and a correct PIN arms.
- Keys 1,2, then idle for TIMEOUT_CYC cycles -> digit_cnt = 0. Then 3,4,ARM -> fail_pulse (short entry), no cmd_arm.
- 1,2,3,4,9,ARM -> the 9 is ignored (digit_cnt stays 4) and cmd_arm pulses. Then 1,2,CLEAR,1,2,3,4,DISARM -> cmd_disarm.
- pin_load with 16'h0042 in IDLE; then 0,0,4,2,DISARM -> cmd_disarm; 1,2,3,4,ARM -> fail_pulse. pin_load asserted during COLLECT -> pin_reg unchanged.
- Two failed checks, then 1,2 entered, then rst_n pulsed low -> outputs 0 and digit_cnt 0 immediately. After reset, one failure does not lock, showing fail_cnt was cleared; pin_reg = 16'h1234.
